// File: rtl/gpio_bus_bridge.sv
// rtl/gpio_bus_bridge.sv - bus register front-end for the GPIO output block
module gpio_bus_bridge #(
   parameter int ADDR_W    = 8,
   parameter int READ_WAIT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_wstrb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [31:0]       gpio_wdata,
   output logic              gpio_we,
   input  logic [31:0]       gpio_rdata,
   input  logic              gpio_oe
);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RDWAIT, S_RESP} state_t;

   state_t      state;
   logic [31:0] shadow;
   logic [15:0] wcount;
   logic [3:0]  wait_cnt;
   logic        rd_status;

   logic [31:0] off;
   logic [2:0]  reg_idx;
   logic        dec_err;
   logic        needs_wait;
   logic        store_pulse;
   logic [31:0] merged;
   logic [31:0] new_shadow;
   logic [31:0] load_imm;

   assign off        = 32'(req_addr);
   assign reg_idx    = off[4:2];
   assign gpio_wdata = shadow;

   // Decode the offered request: error classification and read path selection
   always_comb begin
      dec_err     = (off[1:0] != 2'b00) || (off > 32'h14) ||
                    (req_we && (off == 32'h10 || off == 32'h14));
      needs_wait  = !req_we && (off == 32'h00 || off == 32'h10);
      store_pulse = !(reg_idx == 3'd0 && req_wstrb == 4'h0);
   end

   // Compute the shadow value a store would produce (byte merge for DATA, full word otherwise)
   always_comb begin
      merged = shadow;
      for (int b = 0; b < 4; b++) begin
         if (req_wstrb[b]) merged[8*b +: 8] = req_wdata[8*b +: 8];
      end
      case (reg_idx)
         3'd0:    new_shadow = merged;
         3'd1:    new_shadow = shadow | req_wdata;
         3'd2:    new_shadow = shadow & ~req_wdata;
         3'd3:    new_shadow = shadow ^ req_wdata;
         default: new_shadow = shadow;
      endcase
   end

   // Data returned immediately for loads that do not need the GPIO read latency
   always_comb begin
      case (reg_idx)
         3'd1, 3'd2, 3'd3: load_imm = shadow;
         3'd5:             load_imm = {16'h0000, wcount};
         default:          load_imm = 32'h0;
      endcase
   end

   // Request/response FSM with registered outputs; shadow and counter update on store accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
         gpio_we   <= 1'b0;
         shadow    <= 32'h0;
         wcount    <= 16'h0;
         wait_cnt  <= 4'h0;
         rd_status <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_ready && req_valid) begin
                  req_ready <= 1'b0;
                  if (dec_err) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= 32'h0;
                     state     <= S_RESP;
                  end else if (req_we) begin
                     shadow  <= new_shadow;
                     gpio_we <= store_pulse;
                     if (store_pulse) wcount <= wcount + 16'd1;
                     state   <= S_WRITE;
                  end else if (needs_wait) begin
                     wait_cnt  <= 4'(READ_WAIT - 1);
                     rd_status <= (off == 32'h10);
                     state     <= S_RDWAIT;
                  end else begin
                     rsp_valid <= 1'b1;
                     rsp_rdata <= load_imm;
                     state     <= S_RESP;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            S_WRITE: begin
               gpio_we   <= 1'b0;
               rsp_valid <= 1'b1;
               rsp_rdata <= 32'h0;
               rsp_err   <= 1'b0;
               state     <= S_RESP;
            end
            S_RDWAIT: begin
               if (wait_cnt == 4'h0) begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= rd_status ? {30'h0, (shadow != gpio_rdata), gpio_oe}
                                         : gpio_rdata;
                  state     <= S_RESP;
               end else begin
                  wait_cnt <= wait_cnt - 4'h1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_rdata <= 32'h0;
                  rsp_err   <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_bus_bridge.sv
// tb/tb_gpio_bus_bridge.sv - self-checking bench for gpio_bus_bridge
module tb_gpio_bus_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata, gpio_wdata, gpio_rdata;
   logic        gpio_we, gpio_oe;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_shadow;
   logic [15:0] m_wcount;

   typedef struct {
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] grd;
      logic        oe;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_pulse;
      logic [31:0] exp_shadow;
   } vec_t;

   vec_t tbl[$];

   gpio_bus_bridge #(.ADDR_W(8), .READ_WAIT(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .gpio_wdata(gpio_wdata), .gpio_we(gpio_we),
      .gpio_rdata(gpio_rdata), .gpio_oe(gpio_oe)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic add(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input logic [31:0] grd, input logic oe,
                      input logic [31:0] rd, input logic err, input int lat,
                      input int pulse, input logic [31:0] sh);
      vec_t v;
      v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.grd = grd; v.oe = oe;
      v.exp_rdata = rd; v.exp_err = err; v.exp_lat = lat; v.exp_pulse = pulse;
      v.exp_shadow = sh;
      tbl.push_back(v);
   endtask

   // Reference behaviour straight from the register map rules
   task automatic model_step(input vec_t v, output logic [31:0] rd, output logic err,
                             output int lat, output int pulse);
      logic [31:0] ns;
      rd = 32'h0; lat = 1; pulse = 0;
      err = (v.addr[1:0] != 2'b00) || (v.addr > 8'h14) ||
            (v.we && (v.addr == 8'h10 || v.addr == 8'h14));
      if (err) return;
      if (v.we) begin
         lat = 2;
         ns = m_shadow;
         case (v.addr)
            8'h00: for (int b = 0; b < 4; b++)
                      if (v.wstrb[b]) ns[8*b +: 8] = v.wdata[8*b +: 8];
            8'h04: ns = m_shadow | v.wdata;
            8'h08: ns = m_shadow & ~v.wdata;
            default: ns = m_shadow ^ v.wdata;
         endcase
         pulse = (v.addr == 8'h00 && v.wstrb == 4'h0) ? 0 : 1;
         m_shadow = ns;
         m_wcount = m_wcount + 16'(pulse);
      end else begin
         case (v.addr)
            8'h00: begin lat = 3; rd = v.grd; end
            8'h10: begin lat = 3; rd = {30'h0, (m_shadow != v.grd), v.oe}; end
            8'h14: rd = {16'h0, m_wcount};
            default: rd = m_shadow;
         endcase
      end
   endtask

   // Drive one request, observe latency/pulses, optionally stall the response
   task automatic do_req(input vec_t v, input int hold, output logic [31:0] rd,
                         output logic err, output int lat, output int pulses,
                         output int pulse_cyc, output logic [31:0] pulse_wd);
      int n;
      logic [31:0] r0;
      logic e0;
      lat = -1; pulses = 0; pulse_cyc = -1; pulse_wd = 32'h0; rd = 32'h0; err = 1'b0;
      @(negedge clk);
      req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
      gpio_rdata = v.grd; gpio_oe = v.oe; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      if (!req_ready) begin
         check("accept_timeout", 32'(req_ready), 32'h1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      rsp_ready = (hold == 0);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (gpio_we) begin
            pulses++;
            if (pulse_cyc < 0) begin pulse_cyc = c; pulse_wd = gpio_wdata; end
         end
         if (req_ready) check("req_ready_busy", 32'(req_ready), 32'h0);
         if (rsp_valid) begin lat = c; break; end
      end
      if (lat < 0) begin
         check("rsp_timeout", 32'(rsp_valid), 32'h1);
         rsp_ready = 1'b1;
         return;
      end
      r0 = rsp_rdata; e0 = rsp_err;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check("hold_valid", 32'(rsp_valid), 32'h1);
         check("hold_rdata", rsp_rdata, r0);
         check("hold_err", 32'(rsp_err), 32'(e0));
         check("hold_req_ready", 32'(req_ready), 32'h0);
         if (gpio_we) pulses++;
      end
      rsp_ready = 1'b1;
      rd = r0; err = e0;
      @(posedge clk);
      @(negedge clk);
      check("post_rsp_valid", 32'(rsp_valid), 32'h0);
      check("post_req_ready", 32'(req_ready), 32'h1);
   endtask

   // Run one vector; table vectors use their own expectations, random ones use the model
   task automatic run_vec(input vec_t v, input logic use_tbl, input int hold);
      logic [31:0] rd, mrd;
      logic err, merr;
      int lat, pulses, pcyc, mlat, mpulse;
      logic [31:0] pwd;
      do_req(v, hold, rd, err, lat, pulses, pcyc, pwd);
      model_step(v, mrd, merr, mlat, mpulse);
      if (use_tbl) begin
         mrd = v.exp_rdata; merr = v.exp_err; mlat = v.exp_lat; mpulse = v.exp_pulse;
         m_shadow = v.exp_shadow;
      end
      check($sformatf("rdata@%02h", v.addr), rd, mrd);
      check($sformatf("err@%02h", v.addr), 32'(err), 32'(merr));
      check($sformatf("latency@%02h", v.addr), 32'(lat), 32'(mlat));
      check($sformatf("pulses@%02h", v.addr), 32'(pulses), 32'(mpulse));
      check("gpio_wdata", gpio_wdata, m_shadow);
      if (mpulse == 1) begin
         check("pulse_cycle", 32'(pcyc), 32'h1);
         check("pulse_wdata", pwd, m_shadow);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
      check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
      check({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
      check({tag, "_gpio_we"}, 32'(gpio_we), 32'h0);
      check({tag, "_gpio_wdata"}, gpio_wdata, 32'h0);
   endtask

   // Scenario 1 after a reset: store then WCOUNT must read 1
   task automatic post_reset_store();
      vec_t v;
      v = tbl[0];
      run_vec(v, 1'b1, 0);
      v = tbl[1];
      run_vec(v, 1'b1, 0);
   endtask

   task automatic reset_midflight(input logic we, input int extra_cycles);
      @(negedge clk);
      req_we = we; req_addr = 8'h00; req_wdata = 32'h1234_5678; req_wstrb = 4'hF;
      gpio_rdata = 32'hCAFE_F00D; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int i = 0; i < extra_cycles; i++) @(negedge clk);
      if (we) check("pre_reset_gpio_we", 32'(gpio_we), 32'h1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs(we ? "rst_write" : "rst_rdwait");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (rsp_valid) check("rsp_during_reset", 32'(rsp_valid), 32'h0);
      end
      rst_n = 1'b1;
      m_shadow = 32'h0; m_wcount = 16'h0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rsp_valid || gpio_we) check("stale_activity", {30'h0, rsp_valid, gpio_we}, 32'h0);
      end
      post_reset_store();
   endtask

   initial begin
      vec_t v;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h0; req_wdata = 32'h0;
      req_wstrb = 4'h0; rsp_ready = 1'b1; gpio_rdata = 32'h0; gpio_oe = 1'b0;
      m_shadow = 32'h0; m_wcount = 16'h0;

      //   we    addr   wdata         wstrb grd           oe    rdata         err lat p shadow
      add(1'b1, 8'h00, 32'hA5A51234, 4'hF, 32'h0,       1'b0, 32'h0,        0, 2, 1, 32'hA5A51234);
      add(1'b0, 8'h14, 32'h0,        4'h0, 32'h0,       1'b0, 32'h1,        0, 1, 0, 32'hA5A51234);
      add(1'b1, 8'h00, 32'h000000F0, 4'hF, 32'h0,       1'b0, 32'h0,        0, 2, 1, 32'h000000F0);
      add(1'b1, 8'h04, 32'h0000000F, 4'hF, 32'h0,       1'b0, 32'h0,        0, 2, 1, 32'h000000FF);
      add(1'b1, 8'h08, 32'h00000030, 4'h1, 32'h0,       1'b0, 32'h0,        0, 2, 1, 32'h000000CF);
      add(1'b1, 8'h0C, 32'hFFFF0000, 4'h0, 32'h0,       1'b0, 32'h0,        0, 2, 1, 32'hFFFF00CF);
      add(1'b0, 8'h14, 32'h0,        4'h0, 32'h0,       1'b0, 32'h5,        0, 1, 0, 32'hFFFF00CF);
      add(1'b0, 8'h04, 32'h0,        4'h0, 32'h0,       1'b0, 32'hFFFF00CF, 0, 1, 0, 32'hFFFF00CF);
      add(1'b1, 8'h00, 32'h0,        4'hF, 32'h0,       1'b0, 32'h0,        0, 2, 1, 32'h0);
      add(1'b1, 8'h00, 32'h11223344, 4'h2, 32'h0,       1'b0, 32'h0,        0, 2, 1, 32'h00003300);
      add(1'b1, 8'h00, 32'hFFFFFFFF, 4'h0, 32'h0,       1'b0, 32'h0,        0, 2, 0, 32'h00003300);
      add(1'b0, 8'h14, 32'h0,        4'h0, 32'h0,       1'b0, 32'h7,        0, 1, 0, 32'h00003300);
      add(1'b0, 8'h00, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 0, 3, 0, 32'h00003300);
      add(1'b0, 8'h10, 32'h0,        4'h0, 32'h00003300, 1'b1, 32'h1,        0, 3, 0, 32'h00003300);
      add(1'b0, 8'h10, 32'h0,        4'h0, 32'h0,       1'b1, 32'h3,        0, 3, 0, 32'h00003300);
      add(1'b0, 8'h10, 32'h0,        4'h0, 32'h00003300, 1'b0, 32'h0,        0, 3, 0, 32'h00003300);
      add(1'b0, 8'h02, 32'h0,        4'h0, 32'h0,       1'b0, 32'h0,        1, 1, 0, 32'h00003300);
      add(1'b0, 8'h18, 32'h0,        4'h0, 32'h0,       1'b0, 32'h0,        1, 1, 0, 32'h00003300);
      add(1'b1, 8'h10, 32'hFFFFFFFF, 4'hF, 32'h0,       1'b0, 32'h0,        1, 1, 0, 32'h00003300);
      add(1'b1, 8'h14, 32'hFFFFFFFF, 4'hF, 32'h0,       1'b0, 32'h0,        1, 1, 0, 32'h00003300);
      add(1'b1, 8'h01, 32'hFFFFFFFF, 4'hF, 32'h0,       1'b0, 32'h0,        1, 1, 0, 32'h00003300);
      add(1'b0, 8'h0C, 32'h0,        4'h0, 32'h0,       1'b0, 32'h00003300, 0, 1, 0, 32'h00003300);
      add(1'b0, 8'h08, 32'h0,        4'h0, 32'h0,       1'b0, 32'h00003300, 0, 1, 0, 32'h00003300);
      add(1'b0, 8'h14, 32'h0,        4'h0, 32'h0,       1'b0, 32'h7,        0, 1, 0, 32'h00003300);

      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", 32'(req_ready), 32'h1);

      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         run_vec(v, 1'b1, 0);
      end

      v = tbl[12];
      run_vec(v, 1'b1, 5);

      for (int i = 0; i < 150; i++) begin
         v.we    = 1'($urandom_range(0, 1));
         v.addr  = 8'($urandom_range(0, 8) * 4);
         if ($urandom_range(0, 7) == 0) v.addr = v.addr + 8'($urandom_range(1, 3));
         v.wdata = $urandom;
         v.wstrb = 4'($urandom_range(0, 15));
         v.grd   = ($urandom_range(0, 1) == 1) ? m_shadow : $urandom;
         v.oe    = 1'($urandom_range(0, 1));
         run_vec(v, 1'b0, ($urandom_range(0, 5) == 0) ? 2 : 0);
      end

      reset_midflight(1'b1, 0);
      reset_midflight(1'b0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
